// File: rtl/stim_cmd_parser.sv
// UART byte-stream decoder for stimulation parameters: header, 8-byte body, checksum.
// A parameter set is committed only after its checksum and range checks pass.
module stim_cmd_parser #(
    parameter int         TIMEOUT_CLKS = 500000,
    parameter int         MAX_PULSE_HZ = 100,
    parameter int         MAX_BURST_HZ = 4095,
    parameter logic [7:0] HDR0         = 8'hAA,
    parameter logic [7:0] HDR1         = 8'h55
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic [3:0]  stimulate_mod,
    output logic [11:0] burst_frequency,
    output logic [11:0] pulses_frequency,
    output logic [23:0] igbt_on_time,
    output logic        param_valid,
    output logic        frame_err,
    output logic        busy
);

    localparam int               CNT_W    = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_MODE,
        S_BF_H,
        S_BF_L,
        S_PF_H,
        S_PF_L,
        S_ON_H,
        S_ON_M,
        S_ON_L,
        S_CSUM,
        S_COMMIT
    } state_t;

    state_t           state;
    logic [7:0]       mode_sh;
    logic [15:0]      bf_sh;
    logic [15:0]      pf_sh;
    logic [23:0]      on_sh;
    logic [7:0]       csum;
    logic [CNT_W-1:0] tmo_cnt;
    logic             in_frame;
    logic             tmo_hit;

    // Upper nibbles of the 16-bit frequency fields must be clear; the outputs are 12 bits.
    function automatic logic frame_legal(input logic [7:0]  m,
                                         input logic [15:0] bf,
                                         input logic [15:0] pf,
                                         input logic [23:0] on);
        logic ok;
        ok = (m >= 8'd1) && (m <= 8'd4);
        ok = ok && (bf[15:12] == 4'd0) && (pf[15:12] == 4'd0);
        ok = ok && (pf != 16'd0) && (32'(pf) <= MAX_PULSE_HZ);
        ok = ok && (bf != 16'd0) && (32'(bf) <= MAX_BURST_HZ);
        ok = ok && (on != 24'd0);
        return ok;
    endfunction

    assign in_frame = (state != S_IDLE) && (state != S_COMMIT);
    assign tmo_hit  = in_frame && !rx_done && (tmo_cnt == TMO_LAST);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state            <= S_IDLE;
            mode_sh          <= '0;
            bf_sh            <= '0;
            pf_sh            <= '0;
            on_sh            <= '0;
            csum             <= '0;
            tmo_cnt          <= '0;
            stimulate_mod    <= '0;
            burst_frequency  <= '0;
            pulses_frequency <= '0;
            igbt_on_time     <= '0;
            param_valid      <= 1'b0;
            frame_err        <= 1'b0;
        end else begin
            param_valid <= 1'b0;
            frame_err   <= 1'b0;

            if (rx_done) begin
                tmo_cnt <= '0;
            end else if (in_frame) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (tmo_hit) begin
                state     <= S_IDLE;
                frame_err <= 1'b1;
                tmo_cnt   <= '0;
            end else if (state == S_COMMIT) begin
                // Any byte landing in this single cycle is dropped.
                state <= S_IDLE;
                if (frame_legal(mode_sh, bf_sh, pf_sh, on_sh)) begin
                    stimulate_mod    <= mode_sh[3:0];
                    burst_frequency  <= bf_sh[11:0];
                    pulses_frequency <= pf_sh[11:0];
                    igbt_on_time     <= on_sh;
                    param_valid      <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end else if (rx_done) begin
                case (state)
                    S_IDLE: begin
                        if (rx_data == HDR0) state <= S_HDR;
                    end
                    S_HDR: begin
                        if (rx_data == HDR1) begin
                            state <= S_MODE;
                            csum  <= '0;
                        end else if (rx_data != HDR0) begin
                            state     <= S_IDLE;
                            frame_err <= 1'b1;
                        end
                    end
                    S_MODE: begin
                        mode_sh <= rx_data;
                        csum    <= csum + rx_data;
                        state   <= S_BF_H;
                    end
                    S_BF_H: begin
                        bf_sh[15:8] <= rx_data;
                        csum        <= csum + rx_data;
                        state       <= S_BF_L;
                    end
                    S_BF_L: begin
                        bf_sh[7:0] <= rx_data;
                        csum       <= csum + rx_data;
                        state      <= S_PF_H;
                    end
                    S_PF_H: begin
                        pf_sh[15:8] <= rx_data;
                        csum        <= csum + rx_data;
                        state       <= S_PF_L;
                    end
                    S_PF_L: begin
                        pf_sh[7:0] <= rx_data;
                        csum       <= csum + rx_data;
                        state      <= S_ON_H;
                    end
                    S_ON_H: begin
                        on_sh[23:16] <= rx_data;
                        csum         <= csum + rx_data;
                        state        <= S_ON_M;
                    end
                    S_ON_M: begin
                        on_sh[15:8] <= rx_data;
                        csum        <= csum + rx_data;
                        state       <= S_ON_L;
                    end
                    S_ON_L: begin
                        on_sh[7:0] <= rx_data;
                        csum       <= csum + rx_data;
                        state      <= S_CSUM;
                    end
                    S_CSUM: begin
                        if (rx_data == csum) begin
                            state <= S_COMMIT;
                        end else begin
                            state     <= S_IDLE;
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stim_cmd_parser.sv
// Scoreboard bench for stim_cmd_parser: stimulus pushes expected events, a monitor pops and checks them.
module tb_stim_cmd_parser;

    localparam int TMO = 200;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  rx_data   = 8'h00;
    logic        rx_done   = 1'b0;
    logic [3:0]  stimulate_mod;
    logic [11:0] burst_frequency;
    logic [11:0] pulses_frequency;
    logic [23:0] igbt_on_time;
    logic        param_valid;
    logic        frame_err;
    logic        busy;

    stim_cmd_parser #(.TIMEOUT_CLKS(TMO)) dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .rx_data         (rx_data),
        .rx_done         (rx_done),
        .stimulate_mod   (stimulate_mod),
        .burst_frequency (burst_frequency),
        .pulses_frequency(pulses_frequency),
        .igbt_on_time    (igbt_on_time),
        .param_valid     (param_valid),
        .frame_err       (frame_err),
        .busy            (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          is_err;
        int          at;
        logic [3:0]  m;
        logic [11:0] bf;
        logic [11:0] pf;
        logic [23:0] on;
    } exp_t;

    exp_t sb[$];

    logic [3:0]  cur_m  = '0;
    logic [11:0] cur_bf = '0;
    logic [11:0] cur_pf = '0;
    logic [23:0] cur_on = '0;
    int          last_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input bit is_err, input int at);
        exp_t e;
        e.is_err = is_err;
        e.at     = at;
        e.m      = cur_m;
        e.bf     = cur_bf;
        e.pf     = cur_pf;
        e.on     = cur_on;
        sb.push_back(e);
    endtask

    // One idle cycle before each byte; last_cyc is the cycle index of the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        @(posedge sys_clk);
        @(negedge sys_clk);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge sys_clk);
        #1;
        last_cyc = cyc;
        rx_done  = 1'b0;
        rx_data  = 8'h00;
    endtask

    // code: 0 = commit, 1 = checksum reject, 2 = range reject
    task automatic send_tail(input logic [7:0] m, input logic [15:0] bf, input logic [15:0] pf,
                             input logic [23:0] on, input logic [7:0] adj, input int code);
        logic [7:0] body [8];
        logic [7:0] s;
        body = '{m, bf[15:8], bf[7:0], pf[15:8], pf[7:0], on[23:16], on[15:8], on[7:0]};
        s = 8'h00;
        for (int i = 0; i < 8; i++) begin
            send_byte(body[i]);
            s = s + body[i];
        end
        send_byte(s + adj);
        if (code == 0) begin
            cur_m  = m[3:0];
            cur_bf = bf[11:0];
            cur_pf = pf[11:0];
            cur_on = on;
            push_exp(1'b0, last_cyc + 1);
        end else if (code == 1) begin
            push_exp(1'b1, last_cyc);
        end else begin
            push_exp(1'b1, last_cyc + 1);
        end
        repeat (3) @(posedge sys_clk);
        #1;
        chk("busy_after_frame", 32'(busy), 32'd0);
    endtask

    task automatic send_frame(input logic [7:0] m, input logic [15:0] bf, input logic [15:0] pf,
                              input logic [23:0] on, input logic [7:0] adj, input int code);
        send_byte(8'hAA);
        send_byte(8'h55);
        send_tail(m, bf, pf, on, adj, code);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_mod"},   32'(stimulate_mod),    32'd0);
        chk({tag, "_bf"},    32'(burst_frequency),  32'd0);
        chk({tag, "_pf"},    32'(pulses_frequency), 32'd0);
        chk({tag, "_on"},    32'(igbt_on_time),     32'd0);
        chk({tag, "_busy"},  32'(busy),             32'd0);
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst_n && (param_valid || frame_err)) begin
            chk("pulse_exclusive", 32'(param_valid & frame_err), 32'd0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: pv=%0b fe=%0b at cycle %0d, none queued",
                         param_valid, frame_err, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("event_kind",  32'(frame_err),        32'(e.is_err));
                chk("event_cycle", 32'(cyc),              32'(e.at));
                chk("out_mod",     32'(stimulate_mod),    32'(e.m));
                chk("out_bf",      32'(burst_frequency),  32'(e.bf));
                chk("out_pf",      32'(pulses_frequency), 32'(e.pf));
                chk("out_on",      32'(igbt_on_time),     32'(e.on));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_pv", 32'(param_valid), 32'd0);
        chk("rst_fe", 32'(frame_err),   32'd0);
        chk_outputs_zero("rst");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // AA 55 04 000A 0032 000064, checksum A4
        send_frame(8'd4, 16'd10, 16'd50, 24'd100, 8'd0, 0);
        send_frame(8'd4, 16'd10, 16'd50, 24'd100, 8'd1, 1);

        send_frame(8'd4, 16'd10,     16'd101, 24'd100, 8'd0, 2);
        send_frame(8'd0, 16'd10,     16'd50,  24'd100, 8'd0, 2);
        send_frame(8'd5, 16'd10,     16'd50,  24'd100, 8'd0, 2);
        send_frame(8'd4, 16'd10,     16'd50,  24'd0,   8'd0, 2);
        send_frame(8'd4, 16'd10,     16'd0,   24'd100, 8'd0, 2);
        send_frame(8'd4, 16'd0,      16'd50,  24'd100, 8'd0, 2);
        send_frame(8'd4, 16'h100A,   16'd50,  24'd100, 8'd0, 2);
        send_frame(8'd4, 16'd10,     16'h1032, 24'd100, 8'd0, 2);

        send_frame(8'd1, 16'd4095, 16'd100, 24'hFFFFFF, 8'd0, 0);

        // Partial frame then silence
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h04);
        send_byte(8'h00);
        t0 = last_cyc;
        push_exp(1'b1, t0 + TMO);
        repeat (TMO - 1) @(posedge sys_clk);
        #1;
        chk("busy_before_timeout", 32'(busy), 32'd1);
        @(posedge sys_clk);
        #1;
        chk("busy_after_timeout", 32'(busy), 32'd0);
        repeat (20) @(posedge sys_clk);
        send_frame(8'd2, 16'd1, 16'd1, 24'd1, 8'd0, 0);

        // Resync through repeated HDR0
        send_byte(8'h12);
        send_byte(8'hAA);
        send_byte(8'hAA);
        send_byte(8'hAA);
        send_byte(8'h55);
        send_tail(8'd3, 16'd20, 16'd30, 24'd500, 8'd0, 0);

        // Bad second header byte
        send_byte(8'hAA);
        send_byte(8'h13);
        push_exp(1'b1, last_cyc);
        repeat (2) @(posedge sys_clk);
        #1;
        chk("busy_after_bad_hdr", 32'(busy), 32'd0);

        // Reset in the middle of a frame
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h04);
        send_byte(8'h00);
        chk("busy_mid_frame", 32'(busy), 32'd1);
        sys_rst_n = 1'b0;
        #1;
        chk_outputs_zero("async_rst");
        cur_m  = '0;
        cur_bf = '0;
        cur_pf = '0;
        cur_on = '0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        send_byte(8'h0A);
        send_byte(8'h00);
        send_byte(8'h32);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h64);
        send_byte(8'hA4);
        repeat (4) @(posedge sys_clk);
        #1;
        chk_outputs_zero("tail_ignored");
        send_frame(8'd4, 16'd10, 16'd50, 24'd100, 8'd0, 0);

        repeat (10) @(posedge sys_clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
